// File: rtl/timer_sched.sv
// -----------------------------------------------------------------------------
// timer_sched
//
// Shares one down-counter among N_REQ requesters. An idle block picks one
// active requester by round-robin and loads that requester's delay into the
// counter. The counter then decrements on each tick until it reaches zero,
// and a one-cycle done pulse goes to the owner. The owner can abort by
// dropping its request while in LOAD or RUN.
//
// Handshake: a requester raises req[i] and keeps it high. grant[i] marks
// ownership from the grant cycle through the done cycle. done[i] pulses for
// one cycle, and the requester may then drop req[i]. Dropping req[i] before
// done cancels the run, and that run produces no done.
//
// Ports
//   clk          : clock, rising edge
//   clrn         : asynchronous reset, active low
//   sclr         : synchronous clear, active low, overrides every other input
//   req          : [N_REQ-1:0] level-sensitive requests
//   delay        : [N_REQ*WIDTH-1:0] per-requester delay, slot i at i*WIDTH
//   tick         : count enable, only used in RUN
//   grant        : [N_REQ-1:0] one-hot owner, zero when idle
//   busy         : high whenever the FSM is not in IDLE
//   done         : [N_REQ-1:0] one-cycle completion pulse to the owner
//   cnt_q        : [WIDTH-1:0] shared counter value
//   state_dbg_o  : [1:0] current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
// -----------------------------------------------------------------------------
module timer_sched #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     sclr,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   delay,
  input  logic                     tick,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic [N_REQ-1:0]         done,
  output logic [WIDTH-1:0]         cnt_q,
  output logic [1:0]               state_dbg_o
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q,  gidx_d;
  logic [PW-1:0]    ptr_q,   ptr_d;

  // ---------------------------------------------------------------------------
  // Round-robin search. Doubling the request vector and shifting it right by
  // ptr places the search origin at bit 0. The first set bit at offset off
  // then belongs to requester (ptr + off) mod N_REQ.
  // ---------------------------------------------------------------------------
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               arb_found;
  logic [PW-1:0]      arb_idx;
  logic [PW:0]        arb_sum;
  logic [PW-1:0]      arb_next_ptr;

  always_comb begin
    req_dbl   = {req, req} >> ptr_q;
    req_rot   = req_dbl[N_REQ-1:0];
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!arb_found && req_rot[off]) begin
        arb_found = 1'b1;
        arb_sum   = {1'b0, ptr_q} + (PW+1)'(off);
        if (arb_sum >= (PW+1)'(N_REQ)) begin
          arb_sum = arb_sum - (PW+1)'(N_REQ);
        end
        arb_idx = arb_sum[PW-1:0];
      end
    end
    arb_next_ptr = (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + PW'(1);
  end

  // The owner's delay slot and request bit, indexed by the registered grant.
  logic [WIDTH-1:0] dly_sel;
  logic             req_own;

  always_comb begin
    dly_sel = delay[gidx_q*WIDTH +: WIDTH];
    req_own = req[gidx_q];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;

    if (!sclr) begin
      // Synchronous clear gives the same values as the asynchronous reset.
      state_d = S_IDLE;
      count_d = '0;
      grant_d = '0;
      gidx_d  = '0;
      ptr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_d = '0;
          grant_d = '0;
          if (arb_found) begin
            state_d = S_LOAD;
            gidx_d  = arb_idx;
            grant_d = N_REQ'(1) << arb_idx;
            ptr_d   = arb_next_ptr;
          end
        end

        S_LOAD: begin
          if (!req_own) begin
            state_d = S_IDLE;
            count_d = '0;
            grant_d = '0;
          end else begin
            // The delay is captured here. Later changes on delay have no
            // effect on this run.
            count_d = dly_sel;
            state_d = S_RUN;
          end
        end

        S_RUN: begin
          if (!req_own) begin
            state_d = S_IDLE;
            count_d = '0;
            grant_d = '0;
          end else if (count_q == '0) begin
            // Zero is terminal. The counter never decrements below it.
            state_d = S_DONE;
          end else if (tick) begin
            count_d = count_q - WIDTH'(1);
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
          count_d = '0;
          grant_d = '0;
        end

        default: begin
          state_d = S_IDLE;
          count_d = '0;
          grant_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      count_q <= '0;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. These depend only on registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant       = grant_q;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE) ? grant_q : '0;
    cnt_q       = count_q;
    state_dbg_o = state_q;
  end

endmodule
